// File: rtl/btn_press_counter_pkg.sv
// Shared types and defaults for the button press counter.
// FSM encoding plus default geometry of the prescaler, gap and count.
package btn_press_counter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      GAP,
      EMIT
   } state_t;

   localparam int DEF_DW         = 16;
   localparam int DEF_GAP_TICKS  = 24;
   localparam int DEF_CW         = 4;
   localparam int DEF_LONG_TICKS = 96;

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, prescaler tick and two-sample debounce filter.
// db follows the synchronised input after two agreeing tick samples.
module btn_debounce
   import btn_press_counter_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic db,
   output logic db_rise,
   output logic db_fall,
   output logic tick
);

   logic [1:0]    sync;
   logic [DW-1:0] pre;
   logic          s;
   logic          s_prev;
   logic          agree;

   assign s     = sync[1];
   assign tick  = &pre;
   assign agree = tick && (s == s_prev);

   assign db_rise = agree && s && !db;
   assign db_fall = agree && !s && db;

   // two-flop synchroniser for the asynchronous button level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], btn};
   end

   // free-running prescaler; tick fires when it is all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre <= '0;
      else        pre <= pre + 1'b1;
   end

   // sample on every tick, accept the level once two samples agree
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_prev <= 1'b0;
         db     <= 1'b0;
      end else if (tick) begin
         s_prev <= s;
         if (s == s_prev) db <= s;
      end
   end

endmodule

// File: rtl/btn_press_counter.sv
// Counts debounced button presses and strobes the count after a gap.
// Optional BTN_LONG_PRESS_EN adds long_stb and aborts long-held sequences.
module btn_press_counter
   import btn_press_counter_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int GAP_TICKS = DEF_GAP_TICKS,
   parameter int CW        = DEF_CW
`ifdef BTN_LONG_PRESS_EN
   ,
   parameter int LONG_TICKS = DEF_LONG_TICKS
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          btn,
   output logic [CW-1:0] press_cnt,
   output logic          press_stb,
   output logic          busy
`ifdef BTN_LONG_PRESS_EN
   ,
   output logic          long_stb
`endif
);

   state_t        state, state_n;
   logic [CW-1:0] acc, acc_n;
   logic [7:0]    gap_cnt, gap_n;
   logic          db, db_rise, db_fall, tick;
   logic          abort;

   btn_debounce #(
      .DW(DW)
   ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn    (btn),
      .db     (db),
      .db_rise(db_rise),
      .db_fall(db_fall),
      .tick   (tick)
   );

   assign busy = (state != IDLE);

   // state, accumulator and gap counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         gap_cnt <= gap_n;
      end
   end

   // next-state logic; a rise on the expiry tick keeps the sequence alive
   always_comb begin
      state_n = state;
      acc_n   = acc;
      gap_n   = gap_cnt;
      unique case (state)
         IDLE: begin
            if (db_rise) begin
               state_n = PRESSED;
               acc_n   = CW'(1);
            end
         end
         PRESSED: begin
            if (db_fall) begin
               state_n = GAP;
               gap_n   = '0;
            end
         end
         GAP: begin
            if (db_rise) begin
               state_n = PRESSED;
               gap_n   = '0;
               if (acc != {CW{1'b1}}) acc_n = acc + 1'b1;
            end else if (tick && !db) begin
               if (gap_cnt == 8'(GAP_TICKS - 1)) state_n = EMIT;
               else gap_n = gap_cnt + 8'd1;
            end
         end
         EMIT: begin
            state_n = IDLE;
            acc_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   // publish the count with a one-cycle strobe unless aborted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press_cnt <= '0;
         press_stb <= 1'b0;
      end else begin
         press_stb <= (state == EMIT) && !abort;
         if ((state == EMIT) && !abort) press_cnt <= acc;
      end
   end

`ifdef BTN_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_TICKS + 1);

   logic [LW-1:0] long_cnt;

   // count held ticks per press; reaching the limit aborts the sequence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         long_cnt <= '0;
         long_stb <= 1'b0;
         abort    <= 1'b0;
      end else begin
         long_stb <= 1'b0;
         if (state == IDLE && db_rise) begin
            long_cnt <= '0;
            abort    <= 1'b0;
         end else if (state == GAP && db_rise) begin
            long_cnt <= '0;
         end else if (state == PRESSED && tick && db && !abort) begin
            if (long_cnt == LW'(LONG_TICKS - 1)) begin
               long_stb <= 1'b1;
               abort    <= 1'b1;
            end else begin
               long_cnt <= long_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_counter.sv
// Randomised scoreboard bench for btn_press_counter.
// Expected counts are queued by the stimulus and popped on each strobe.
module tb_btn_press_counter;

   localparam int DW = 5;
   localparam int GT = 16;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
   localparam int IDLE_END = 900;
`ifdef BTN_LONG_PRESS_EN
   localparam int HI_MIN = 110;
   localparam int HI_MAX = 160;
   localparam int HI_FIX = 150;
`else
   localparam int HI_MIN = 120;
   localparam int HI_MAX = 400;
   localparam int HI_FIX = 400;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          btn = 1'b0;
   logic [CW-1:0] press_cnt;
   logic          press_stb;
   logic          busy;
`ifdef BTN_LONG_PRESS_EN
   logic          long_stb;
`endif

   always #5 clk = ~clk;

   btn_press_counter #(
      .DW(DW),
      .GAP_TICKS(GT),
      .CW(CW)
`ifdef BTN_LONG_PRESS_EN
      ,
      .LONG_TICKS(8)
`endif
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn      (btn),
      .press_cnt(press_cnt),
      .press_stb(press_stb),
      .busy     (busy)
`ifdef BTN_LONG_PRESS_EN
      ,
      .long_stb (long_stb)
`endif
   );

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int nstb = 0;
   int nexp = 0;
   int nlong = 0;
   bit chk_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_count(input int presses);
      return (presses > SAT) ? SAT : presses;
   endfunction

   // monitor: pop the expectation whenever a strobe appears
   always @(negedge clk) begin
      if (chk_busy) begin
         chk_busy = 1'b0;
         check("busy_after_stb", {31'd0, busy}, 0);
      end
      if (rst_n && press_stb) begin
         nstb++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_stb: press_cnt %0d, none expected",
                     press_cnt);
         end else begin
            check("press_cnt", {28'd0, press_cnt}, exp_q.pop_front());
         end
         chk_busy = 1'b1;
      end
`ifdef BTN_LONG_PRESS_EN
      if (rst_n && long_stb) nlong++;
`endif
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hi, input int lo);
      btn = 1'b1;
      cyc(hi);
      btn = 1'b0;
      cyc(lo);
   endtask

   task automatic bounce(input logic v);
      for (int i = 0; i < 6; i++) begin
         btn = v;
         cyc(5);
         btn = !v;
         cyc(5);
      end
      btn = v;
   endtask

   task automatic expect_seq(input int presses);
      exp_q.push_back(model_count(presses));
      nexp++;
   endtask

   initial begin
      int n;
      int t;
      cyc(3);
      check("rst_cnt", {28'd0, press_cnt}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_stb", {31'd0, press_stb}, 0);
      rst_n = 1'b1;

      cyc(1000);
      check("idle_cnt", {28'd0, press_cnt}, 0);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_nstb", nstb, 0);

      expect_seq(3);
      for (int i = 0; i < 3; i++) press(HI_FIX, 300);
      cyc(IDLE_END);

      expect_seq(1);
      bounce(1'b1);
      cyc(HI_FIX);
      bounce(1'b0);
      cyc(IDLE_END);

      expect_seq(20);
      for (int i = 0; i < 20; i++) press(HI_FIX, 200);
      cyc(IDLE_END);
      check("pre_rst_drain", exp_q.size(), 0);

      press(HI_FIX, 200);
      press(HI_FIX, 150);
      check("gap_busy", {31'd0, busy}, 1);
      rst_n = 1'b0;
      cyc(3);
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_cnt", {28'd0, press_cnt}, 0);
      rst_n = 1'b1;
      expect_seq(1);
      press(HI_FIX, 200);
      cyc(IDLE_END);

      for (int s = 0; s < 5; s++) begin
         n = $urandom_range(1, 8);
         expect_seq(n);
         for (int i = 0; i < n; i++)
            press($urandom_range(HI_MIN, HI_MAX), $urandom_range(120, 350));
         cyc(IDLE_END);
      end

      t = 0;
      while (exp_q.size() > 0 && t < 5000) begin
         cyc(1);
         t++;
      end
      check("queue_drained", exp_q.size(), 0);
      check("strobe_total", nstb, nexp);
      check("end_busy", {31'd0, busy}, 0);

`ifdef BTN_LONG_PRESS_EN
      check("long_none_yet", nlong, 0);
      press(400, IDLE_END);
      check("long_once", nlong, 1);
      check("long_no_stb", nstb, nexp);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
